// File: rtl/jk_register_bank.sv
// jk_register_bank: WIDTH JK flip-flops with a shared prescaler, parallel load and an up/down counter mode.
// Rev 1.0
`default_nettype none

module jk_register_bank #(
  parameter int WIDTH = 8,
  parameter int DIV   = 50_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic             clk_out,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             carry
);

  localparam int             CW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  LAST      = CW'(DIV - 1);
  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
  localparam logic [WIDTH-1:0] Q_ONE   = WIDTH'(1);
  localparam logic [1:0]     MODE_JK   = 2'b00;
  localparam logic [1:0]     MODE_UP   = 2'b01;
  localparam logic [1:0]     MODE_DN   = 2'b10;

  logic [CW-1:0]    count;
  logic             tick;
  logic [WIDTH-1:0] q_next;
  logic             carry_next;

  // With DIV=1 the count is pinned at 0, so tick is permanently high.
  assign tick = (count == LAST);

  always_comb begin
    q_next     = q;
    carry_next = 1'b0;
    case (mode)
      MODE_JK: q_next = (j & ~q) | (~k & q);
      MODE_UP: begin
        q_next     = q + Q_ONE;
        carry_next = &q;
      end
      MODE_DN: begin
        q_next     = q - Q_ONE;
        carry_next = ~|q;
      end
      default: q_next = q;
    endcase
  end

  // qbar is a separate register loaded with the complement of q's next value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q       <= '0;
      qbar    <= '1;
      clk_out <= 1'b0;
      carry   <= 1'b0;
      count   <= '0;
    end else if (load) begin
      q       <= d;
      qbar    <= ~d;
      count   <= '0;
      carry   <= 1'b0;
    end else if (tick) begin
      q       <= q_next;
      qbar    <= ~q_next;
      count   <= '0;
      clk_out <= ~clk_out;
      carry   <= carry_next;
    end else begin
      count   <= count + CNT_ONE;
      carry   <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_jk_register_bank.sv
// Scoreboard bench: four banks (DIV=1..4) share stimulus and are checked against a behavioural model.
`default_nettype none

module tb_jk_register_bank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] j = '0, k = '0, d = '0;
  logic [1:0] mode = 2'b11;
  logic       load = 1'b0;

  logic [7:0] q_w  [1:4];
  logic [7:0] qb_w [1:4];
  logic       co_w [1:4];
  logic       cy_w [1:4];

  always #5 clk = ~clk;

  for (genvar g = 1; g <= 4; g++) begin : g_dut
    jk_register_bank #(.WIDTH(8), .DIV(g)) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .j       (j),
      .k       (k),
      .mode    (mode),
      .load    (load),
      .d       (d),
      .clk_out (co_w[g]),
      .q       (q_w[g]),
      .qbar    (qb_w[g]),
      .carry   (cy_w[g])
    );
  end

  typedef struct {
    int         idx;
    logic [7:0] q;
    logic       co;
    logic       cy;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: value, edges since last tick, square wave and carry per instance.
  int m_q  [1:4];
  int m_ph [1:4];
  bit m_co [1:4];
  bit m_cy [1:4];

  function automatic void model_reset(input int n);
    m_q[n] = 0; m_ph[n] = 0; m_co[n] = 0; m_cy[n] = 0;
  endfunction

  function automatic void model_edge(input int n);
    int nq;
    if (!rst_n) begin
      model_reset(n);
    end else if (load) begin
      m_q[n] = int'(d); m_ph[n] = 0; m_cy[n] = 0;
    end else if (m_ph[n] == n - 1) begin
      m_ph[n] = 0;
      m_co[n] = !m_co[n];
      m_cy[n] = 0;
      nq = m_q[n];
      case (mode)
        2'b00: begin
          for (int b = 0; b < 8; b++) begin
            case ({j[b], k[b]})
              2'b01:   nq = nq & ~(1 << b);
              2'b10:   nq = nq | (1 << b);
              2'b11:   nq = nq ^ (1 << b);
              default: nq = nq;
            endcase
          end
        end
        2'b01: begin
          m_cy[n] = (m_q[n] == 255);
          nq = (m_q[n] + 1) % 256;
        end
        2'b10: begin
          m_cy[n] = (m_q[n] == 0);
          nq = (m_q[n] + 255) % 256;
        end
        default: nq = m_q[n];
      endcase
      m_q[n] = nq;
    end else begin
      m_ph[n] = m_ph[n] + 1;
      m_cy[n] = 0;
    end
  endfunction

  task automatic step(input bit r, input bit ld, input bit [1:0] m,
                      input bit [7:0] dd, input bit [7:0] jj, input bit [7:0] kk);
    exp_t e;
    @(posedge clk);
    for (int n = 1; n <= 4; n++) model_edge(n);
    #1;
    rst_n = r; load = ld; mode = m; d = dd; j = jj; k = kk;
    if (!r) for (int n = 1; n <= 4; n++) model_reset(n);
    for (int n = 1; n <= 4; n++) begin
      e.idx = n; e.q = m_q[n][7:0]; e.co = m_co[n]; e.cy = m_cy[n];
      sb.push_back(e);
    end
  endtask

  // Monitor: compares every pending expectation against the matching instance.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (q_w[e.idx] !== e.q) begin
        errors++;
        $display("FAIL q div%0d t=%0t got %h expected %h", e.idx, $time, q_w[e.idx], e.q);
      end
      checks++;
      if (qb_w[e.idx] !== ~e.q) begin
        errors++;
        $display("FAIL qbar div%0d t=%0t got %h expected %h", e.idx, $time, qb_w[e.idx], ~e.q);
      end
      checks++;
      if (co_w[e.idx] !== e.co) begin
        errors++;
        $display("FAIL clk_out div%0d t=%0t got %b expected %b", e.idx, $time, co_w[e.idx], e.co);
      end
      checks++;
      if (cy_w[e.idx] !== e.cy) begin
        errors++;
        $display("FAIL carry div%0d t=%0t got %b expected %b", e.idx, $time, cy_w[e.idx], e.cy);
      end
    end
  end

  initial begin
    for (int n = 1; n <= 4; n++) model_reset(n);

    // Reset held with random inputs, then released into up-count.
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'($urandom), 2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    step(1'b1, 1'b0, 2'b01, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 2'b01, 8'h00, 8'h00, 8'h00);

    // JK truth table from a preload of F0.
    step(1'b1, 1'b1, 2'b00, 8'hF0, 8'h00, 8'h00);
    step(1'b1, 1'b0, 2'b00, 8'h00, 8'h3C, 8'hC3);
    step(1'b1, 1'b0, 2'b00, 8'h00, 8'hFF, 8'hFF);
    step(1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00);

    // Hold mode: prescaler and clk_out keep running.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 2'b11, 8'h00, 8'hFF, 8'hFF);

    // Up-wrap from FE.
    step(1'b1, 1'b1, 2'b01, 8'hFE, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 2'b01, 8'h00, 8'h00, 8'h00);

    // Down-wrap from 01, then a load landing on a DIV=3 tick edge.
    step(1'b1, 1'b1, 2'b10, 8'h01, 8'h00, 8'h00);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 2'b10, 8'h00, 8'h00, 8'h00);
    step(1'b1, 1'b1, 2'b10, 8'h55, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 2'b10, 8'h00, 8'h00, 8'h00);

    // Asynchronous reset in the middle of up-counting.
    step(1'b1, 1'b1, 2'b01, 8'h80, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 2'b01, 8'h00, 8'h00, 8'h00);
    step(1'b0, 1'b0, 2'b01, 8'h00, 8'h00, 8'h00);
    step(1'b0, 1'b0, 2'b01, 8'h00, 8'h00, 8'h00);
    step(1'b1, 1'b0, 2'b01, 8'h00, 8'h00, 8'h00);

    // Randomised traffic, including loads near all-ones/all-zeros and rare resets.
    for (int i = 0; i < 400; i++) begin
      bit [7:0] dd;
      dd = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 8'hFF : 8'h00) : 8'($urandom);
      step($urandom_range(0, 99) != 0, $urandom_range(0, 9) == 0, 2'($urandom),
           dd, 8'($urandom), 8'($urandom));
    end

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending %0d expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/jk_register_bank.md
# jk_register_bank

Parametrised bank of WIDTH JK flip-flops sharing one clock, with a built-in prescaler that gates state updates and a mode input that turns the bank into a synchronous up or down counter. It is the general-purpose successor to the single JK cell in the sequential-circuit experiments: the same standard JK behaviour, but multi-bit, with parallel load and a slow visible clock for board-level LED observation.

## Interface
- WIDTH, 8: number of flip-flops or counter bits; minimum 1.
- DIV, 50_000_000: Clk cycles per update tick; minimum 1 (1 = update every cycle).
- Clk  input  1  system clock; all state changes on its rising edge.
- Rst_n  input  1  asynchronous, active-low reset.
- J  input  WIDTH  per-bit J input, used in JK mode.
- K  input  WIDTH  per-bit K input, used in JK mode.
- Mode  input  2  00 JK bank, 01 up-counter, 10 down-counter, 11 hold.
- Load  input  1  synchronous parallel load request.
- D  input  WIDTH  parallel load data.
- Clk_out  output  1  prescaled square wave that toggles on every tick.
- Q  output  WIDTH  registered state.
- Qbar  output  WIDTH  registered complement; always equals ~Q.
- Carry  output  1  one-cycle pulse on a counter wrap.

## Operation
- Prescaler: a counter of width clog2(DIV), minimum 1, runs 0..DIV-1 and then wraps to 0.
  - Internal tick = (count == DIV-1). For DIV=1, tick is constantly 1.
- Priority on each rising Clk edge, highest first:
  - Load=1: Q <= D and Qbar <= ~D regardless of tick or Mode. The prescaler count restarts at 0, Clk_out is unchanged and Carry is 0.
  - Otherwise, tick=1: Q updates according to Mode, the prescaler wraps to 0, Clk_out toggles.
  - Otherwise: Q holds, the prescaler increments, Carry is 0.
- Mode 00 (JK), applied per bit i:
  - J=0, K=0: hold.
  - J=0, K=1: clear.
  - J=1, K=0: set.
  - J=1, K=1: toggle.
- Mode 01 (up-counter):
  - Q <= Q+1, modulo 2^WIDTH. This is equivalent to bit i toggling when all lower bits are 1.
  - Carry=1 for that cycle if Q was all ones before the update.
- Mode 10 (down-counter):
  - Q <= Q-1, modulo 2^WIDTH.
  - Carry=1 for that cycle if Q was all zeros before the update (borrow).
- Mode 11: Q holds. The prescaler and Clk_out keep running.
- J and K are ignored in modes 01, 10 and 11.
- Carry is never asserted in mode 00 or mode 11.
- Qbar is its own register, written with the complement of Q's next value. It must never differ from ~Q, including out of reset.
- A Mode change takes effect at the next tick. No pipeline state depends on the previous mode.

## Timing
- Reset values, applied immediately on Rst_n low and independent of Clk:
  - Q = 0, Qbar = all ones.
  - Clk_out = 0, Carry = 0, prescaler = 0.
- After Rst_n deasserts, the first tick occurs on the DIV-th rising edge.
- Clk_out period = 2·DIV Clk cycles with 50 % duty, except when a Load restarts the prescaler.
- Latency from the inputs sampled on a tick edge to Q: one edge. Load latency is one edge.
- Carry is registered. It is high for exactly the one Clk cycle following the wrapping edge, and is 0 when DIV=1 and no wrap occurs.
- Simultaneous Load and tick: Load wins. No count or JK update occurs, and Clk_out does not toggle.
- Reset asserted mid-count or mid-Clk_out high: all outputs go to their reset values at once, and the prescaler phase is lost.
- All inputs are synchronous to Clk. Synchronising board switches is the integrator's responsibility.

## Test plan
- Reset: hold Rst_n=0 for 3 cycles with random inputs, then release with DIV=4.
  - During reset: Q=0x00, Qbar=0xFF, Clk_out=0, Carry=0.
  - First Q change on the 4th edge after release.
- JK truth table, DIV=1, WIDTH=8, Q preloaded to 0xF0, Mode=00:
  - J=0x3C, K=0xC3 → Q=0x3C, Qbar=0xC3.
  - Then J=K=0xFF → Q=0xC3.
  - Then J=K=0x00 → Q holds at 0xC3.
- Prescaler, DIV=4, Mode=11:
  - Clk_out toggles every 4 edges, giving a period of 8 cycles.
  - Q is unchanged throughout.
- Up-wrap, DIV=1, Mode=01:
  - Load D=0xFE, then run 2 ticks → Q goes 0xFF, then 0x00.
  - Carry=1 for exactly the cycle after the 0xFF→0x00 edge.
- Down-wrap and Load priority, DIV=3, Mode=10:
  - Load D=0x01, then 2 ticks → Q goes 0x00, then 0xFF with Carry pulse.
  - Assert Load D=0x55 on a tick edge → Q=0x55, no decrement, no Clk_out toggle, next tick 3 edges later.
- Reset mid-operation: up-counting at DIV=2, pull Rst_n low asynchronously between edges.
  - Q, Qbar, Clk_out and Carry go to their reset values before the next edge.
